// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared state encoding, control bundle and hazard helpers for the MIPS pipeline hazard controller.
package mips_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE   = ctrl_t'(7'b1111000);
    localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b0000001);
    localparam ctrl_t CTRL_HALT   = ctrl_t'(7'b0000000);

    // $zero is never a real producer, so a load into it cannot create a hazard.
    function automatic logic load_use(input logic       ex_mem_read,
                                      input logic [4:0] ex_wr,
                                      input logic [4:0] rs,
                                      input logic [4:0] rt,
                                      input logic       uses_rt);
        return ex_mem_read && (ex_wr != REG_ZERO) &&
               ((ex_wr == rs) || ((ex_wr == rt) && uses_rt));
    endfunction

    // Control-flow / data hazard rules once memory is not holding the pipeline.
    function automatic ctrl_t run_ctrl(input logic branch_taken,
                                       input logic lu,
                                       input logic jmp);
        ctrl_t c;
        c = CTRL_IDLE;
        if (branch_taken) begin
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (lu) begin
            c.pc_en      = 1'b0;
            c.ifid_en    = 1'b0;
            c.idex_flush = 1'b1;
        end else if (jmp) begin
            c.ifid_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline-side signal bundle of the hazard controller: hazard sources in, stage enables/flushes out.
interface pipeline_hazard_controller_if #(
    parameter int CNT_WIDTH = 16
);
    logic [4:0]           id_rs_i;
    logic [4:0]           id_rt_i;
    logic                 id_uses_rt_i;
    logic                 ex_mem_read_i;
    logic [4:0]           ex_write_register_i;
    logic                 jmp_i;
    logic                 branch_taken_i;
    logic                 mem_access_i;
    logic                 mem_ready_i;

    logic                 pc_enable_o;
    logic                 ifid_enable_o;
    logic                 idex_enable_o;
    logic                 exmem_enable_o;
    logic                 ifid_flush_o;
    logic                 idex_flush_o;
    logic                 memwb_flush_o;
    logic                 mem_error_o;
    logic [CNT_WIDTH-1:0] cnt_stall_o;
    logic [CNT_WIDTH-1:0] cnt_flush_o;

    modport master (
        output id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_write_register_i,
               jmp_i, branch_taken_i, mem_access_i, mem_ready_i,
        input  pc_enable_o, ifid_enable_o, idex_enable_o, exmem_enable_o,
               ifid_flush_o, idex_flush_o, memwb_flush_o, mem_error_o,
               cnt_stall_o, cnt_flush_o
    );

    modport slave (
        input  id_rs_i, id_rt_i, id_uses_rt_i, ex_mem_read_i, ex_write_register_i,
               jmp_i, branch_taken_i, mem_access_i, mem_ready_i,
        output pc_enable_o, ifid_enable_o, idex_enable_o, exmem_enable_o,
               ifid_flush_o, idex_flush_o, memwb_flush_o, mem_error_o,
               cnt_stall_o, cnt_flush_o
    );

endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline with a data-memory wait watchdog.
// Define PERF_COUNTERS_EN to build the stall/flush performance counters.
module pipeline_hazard_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 16
) (
    input logic                         clk,
    input logic                         reset,
    pipeline_hazard_controller_if.slave bus
);

    localparam int              WAIT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    state_t              state;
    state_t              state_nxt;
    ctrl_t               ctrl;
    logic                lu;
    logic                wait_inc;
    logic                wait_clr;
    logic                set_err;
    logic                mem_error;
    logic [WAIT_W-1:0]   wait_cnt;

    assign lu = load_use(bus.ex_mem_read_i, bus.ex_write_register_i,
                         bus.id_rs_i, bus.id_rt_i, bus.id_uses_rt_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_error <= 1'b0;
        end else if (set_err) begin
            mem_error <= 1'b1;
        end
    end

    // wait_cnt idles at 0 in RUN, so the entry increment lands it on 1.
    hazard_sat_counter #(.CNT_WIDTH(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (wait_clr),
        .inc   (wait_inc),
        .count (wait_cnt)
    );

    always_comb begin
        state_nxt = state;
        ctrl      = CTRL_IDLE;
        wait_inc  = 1'b0;
        wait_clr  = 1'b0;
        set_err   = 1'b0;
        unique case (state)
            ST_RUN: begin
                if (bus.mem_access_i && !bus.mem_ready_i) begin
                    ctrl      = CTRL_FREEZE;
                    state_nxt = ST_MEM_WAIT;
                    wait_inc  = 1'b1;
                end else begin
                    ctrl = run_ctrl(bus.branch_taken_i, lu, bus.jmp_i);
                end
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ready_i) begin
                    ctrl      = run_ctrl(bus.branch_taken_i, lu, bus.jmp_i);
                    state_nxt = ST_RUN;
                    wait_clr  = 1'b1;
                end else if (wait_cnt == TIMEOUT_CNT) begin
                    ctrl      = CTRL_FREEZE;
                    state_nxt = ST_ERROR;
                    set_err   = 1'b1;
                end else begin
                    ctrl     = CTRL_FREEZE;
                    wait_inc = 1'b1;
                end
            end
            ST_ERROR: begin
                ctrl = CTRL_HALT;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        // Outputs must read as a free-running pipeline while reset is held.
        if (!reset) begin
            ctrl = CTRL_IDLE;
        end
    end

    assign bus.pc_enable_o    = ctrl.pc_en;
    assign bus.ifid_enable_o  = ctrl.ifid_en;
    assign bus.idex_enable_o  = ctrl.idex_en;
    assign bus.exmem_enable_o = ctrl.exmem_en;
    assign bus.ifid_flush_o   = ctrl.ifid_flush;
    assign bus.idex_flush_o   = ctrl.idex_flush;
    assign bus.memwb_flush_o  = ctrl.memwb_flush;
    assign bus.mem_error_o    = mem_error;

`ifdef PERF_COUNTERS_EN
    logic                 stall_inc;
    logic                 flush_inc;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;

    assign stall_inc = !ctrl.pc_en;
    assign flush_inc = ctrl.ifid_flush | ctrl.idex_flush | ctrl.memwb_flush;

    hazard_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    hazard_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign bus.cnt_stall_o = stall_cnt;
    assign bus.cnt_flush_o = flush_cnt;
`else
    assign bus.cnt_stall_o = {CNT_WIDTH{1'b0}};
    assign bus.cnt_flush_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed table, corner sequences, random vs. model.
module tb_pipeline_hazard_controller;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 16;
    localparam int CMAX    = (1 << CNT_W) - 1;
`ifdef PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.CNT_WIDTH(CNT_W)) bus ();

    pipeline_hazard_controller #(.MEM_TIMEOUT(TIMEOUT), .CNT_WIDTH(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic       sc_clr;
    logic       sc_inc;
    logic [2:0] sc_count;

    hazard_sat_counter #(.CNT_WIDTH(3)) u_sc (
        .clk   (clk),
        .reset (reset),
        .clr   (sc_clr),
        .inc   (sc_inc),
        .count (sc_count)
    );

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       ex_rd;
        logic [4:0] ex_wr;
        logic       jmp;
        logic       br;
        logic       acc;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: pipeline "waiting on memory" and "dead" flags plus event tallies.
    bit m_wait;
    bit m_err;
    int m_waited;
    int m_stalls;
    int m_flushes;

    function automatic vec_t mk(input int rs, input int rt, input bit uses, input bit exrd,
                                input int exwr, input bit jmp, input bit br, input bit acc,
                                input bit rdy, input logic [6:0] exp);
        vec_t v;
        v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = uses; v.ex_rd = exrd; v.ex_wr = 5'(exwr);
        v.jmp = jmp; v.br = br; v.acc = acc; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        v.rs      = 5'($urandom_range(0, 3));
        v.rt      = 5'($urandom_range(0, 3));
        v.uses_rt = 1'($urandom_range(0, 1));
        v.ex_rd   = 1'($urandom_range(0, 1));
        v.ex_wr   = 5'($urandom_range(0, 3));
        v.jmp     = 1'($urandom_range(0, 3) == 0);
        v.br      = 1'($urandom_range(0, 4) == 0);
        v.acc     = 1'($urandom_range(0, 9) < 3);
        v.rdy     = 1'($urandom_range(0, 1));
        v.exp     = '0;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.id_rs_i             = v.rs;
        bus.id_rt_i             = v.rt;
        bus.id_uses_rt_i        = v.uses_rt;
        bus.ex_mem_read_i       = v.ex_rd;
        bus.ex_write_register_i = v.ex_wr;
        bus.jmp_i               = v.jmp;
        bus.branch_taken_i      = v.br;
        bus.mem_access_i        = v.acc;
        bus.mem_ready_i         = v.rdy;
    endtask

    function automatic logic [6:0] dut_ctrl();
        return {bus.pc_enable_o, bus.ifid_enable_o, bus.idex_enable_o, bus.exmem_enable_o,
                bus.ifid_flush_o, bus.idex_flush_o, bus.memwb_flush_o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Bits: {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush}
    function automatic logic [6:0] model_ctrl();
        bit lu;
        bit hold;
        lu = bus.ex_mem_read_i && (bus.ex_write_register_i != 5'd0) &&
             ((bus.ex_write_register_i == bus.id_rs_i) ||
              (bus.ex_write_register_i == bus.id_rt_i && bus.id_uses_rt_i));
        hold = !bus.mem_ready_i && (m_wait || bus.mem_access_i);
        if (m_err)               return 7'b0000000;
        if (hold)                return 7'b0000001;
        if (bus.branch_taken_i)  return 7'b1111110;
        if (lu)                  return 7'b0011010;
        if (bus.jmp_i)           return 7'b1111100;
        return 7'b1111000;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_err = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
    endtask

    task automatic model_advance(input logic [6:0] e);
        if (m_err) begin
            m_err = 1;
        end else if (m_wait) begin
            if (bus.mem_ready_i) m_wait = 0;
            else if (m_waited == TIMEOUT) begin m_err = 1; m_wait = 0; end
            else m_waited++;
        end else if (bus.mem_access_i && !bus.mem_ready_i) begin
            m_wait = 1;
            m_waited = 1;
        end
        if (!e[6] && m_stalls < CMAX) m_stalls++;
        if ((|e[2:0]) && m_flushes < CMAX) m_flushes++;
    endtask

    task automatic step(input string nm);
        logic [6:0] e;
        e = model_ctrl();
        chk({nm, " ctrl"}, 32'(dut_ctrl()), 32'(e));
        chk({nm, " mem_error"}, 32'(bus.mem_error_o), 32'(m_err));
        chk({nm, " cnt_stall"}, 32'(bus.cnt_stall_o), PERF ? 32'(m_stalls) : 32'd0);
        chk({nm, " cnt_flush"}, 32'(bus.cnt_flush_o), PERF ? 32'(m_flushes) : 32'd0);
        model_advance(e);
    endtask

    task automatic cyc(input vec_t v, input string nm);
        @(negedge clk);
        reset = 1'b1;
        apply(v);
        #1;
        step(nm);
    endtask

    task automatic cyc_exp(input vec_t v, input string nm);
        @(negedge clk);
        reset = 1'b1;
        apply(v);
        #1;
        chk({nm, " table"}, 32'(dut_ctrl()), 32'(v.exp));
        step(nm);
    endtask

    task automatic do_reset(input vec_t v, input string nm);
        @(negedge clk);
        reset = 1'b0;
        apply(v);
        #1;
        chk({nm, " ctrl"}, 32'(dut_ctrl()), 32'h78);
        chk({nm, " mem_error"}, 32'(bus.mem_error_o), 32'd0);
        chk({nm, " cnt_stall"}, 32'(bus.cnt_stall_o), 32'd0);
        chk({nm, " cnt_flush"}, 32'(bus.cnt_flush_o), 32'd0);
        model_reset();
    endtask

    vec_t tbl [12];
    vec_t idle, lu_v, freeze_v;

    initial begin
        int base_stall;
        int err_cycles;
        idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1111000);
        lu_v     = mk(8, 3, 0, 1, 8, 0, 0, 0, 0, 7'b0011010);
        freeze_v = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0000001);
        tbl[0]  = idle;
        tbl[1]  = lu_v;
        tbl[2]  = mk(0, 4, 1, 1, 0, 0, 0, 0, 0, 7'b1111000);   // lw $zero
        tbl[3]  = mk(2, 9, 1, 1, 9, 0, 0, 0, 0, 7'b0011010);   // hazard through rt
        tbl[4]  = mk(2, 9, 0, 1, 9, 0, 0, 0, 0, 7'b1111000);   // rt not read
        tbl[5]  = mk(8, 3, 0, 0, 8, 0, 0, 0, 0, 7'b1111000);   // not a load
        tbl[6]  = mk(8, 3, 0, 1, 8, 0, 1, 0, 0, 7'b1111110);   // branch beats lu
        tbl[7]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 7'b1111100);   // jump
        tbl[8]  = mk(8, 3, 0, 1, 8, 1, 0, 0, 0, 7'b0011010);   // lu beats jump
        tbl[9]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 7'b1111110);   // branch beats jump
        tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 7'b1111100);   // ready with access
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1111000);

        reset = 1'b0;
        sc_clr = 1'b0;
        sc_inc = 1'b0;
        apply(idle);
        repeat (2) @(negedge clk);
        do_reset(mk(8, 3, 0, 1, 8, 1, 0, 1, 0, 7'b0), "reset state");

        // Small saturating counter, pipeline idle in RUN meanwhile.
        @(negedge clk);
        reset = 1'b1;
        apply(idle);
        sc_inc = 1'b1;
        repeat (3) @(negedge clk);
        #1 chk("satcnt count3", 32'(sc_count), 32'd3);
        repeat (7) @(negedge clk);
        #1 chk("satcnt saturate", 32'(sc_count), 32'd7);
        sc_inc = 1'b0;
        sc_clr = 1'b1;
        @(negedge clk);
        sc_clr = 1'b0;
        #1 chk("satcnt clear", 32'(sc_count), 32'd0);

        for (int i = 0; i < 12; i++) cyc_exp(tbl[i], $sformatf("vec%0d", i));

        // Load-use: one bubble, then the load has left EX.
        cyc_exp(lu_v, "lu stall");
        cyc_exp(idle, "lu release");

        // Memory wait of three cycles, then ready.
        base_stall = int'(bus.cnt_stall_o);
        cyc_exp(freeze_v, "mw enter");
        for (int i = 0; i < 3; i++) cyc_exp(freeze_v, $sformatf("mw wait%0d", i));
        cyc_exp(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1111000), "mw ready");
        cyc_exp(idle, "mw after");
        chk("mw stall count", 32'(int'(bus.cnt_stall_o) - base_stall), PERF ? 32'd4 : 32'd0);

        // Ready arriving in MEM_WAIT resumes with the held hazard applied.
        cyc_exp(mk(8, 3, 0, 1, 8, 0, 0, 1, 0, 7'b0000001), "mw lu enter");
        cyc_exp(mk(8, 3, 0, 1, 8, 0, 0, 1, 1, 7'b0011010), "mw lu ready");
        cyc_exp(idle, "mw lu after");

        // Watchdog: memory never answers.
        cyc_exp(freeze_v, "to enter");
        for (int i = 0; i < TIMEOUT; i++) cyc_exp(freeze_v, $sformatf("to wait%0d", i));
        for (int i = 0; i < 3; i++)
            cyc_exp(mk(8, 3, 0, 1, 8, 1, 1, 1, 1, 7'b0000000), $sformatf("to error%0d", i));
        chk("to sticky error", 32'(bus.mem_error_o), 32'd1);
        do_reset(idle, "to reset");
        cyc_exp(idle, "to recovered");

        // Reset while waiting on memory.
        cyc_exp(freeze_v, "rmw enter");
        cyc_exp(freeze_v, "rmw wait");
        do_reset(freeze_v, "rmw reset");
        cyc_exp(lu_v, "rmw run after");
        cyc_exp(idle, "rmw idle");

        err_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (err_cycles > 2 || $urandom_range(0, 99) == 0) begin
                do_reset(rnd_vec(), "rand reset");
                err_cycles = 0;
            end else begin
                cyc(rnd_vec(), $sformatf("rand%0d", n));
                if (m_err) err_cycles++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
